// File: rtl/ifm_wgt_feeder_if.sv
// ifm_wgt_feeder_if: bundles the core request/response strobes and the buffer SRAM
// port of the feeder.
//   master : core + SRAM side (drives requests and mem_rdata, observes feeder outputs)
//   slave  : the feeder itself
// Signals: start_conv, ifm_read, wgt_read (requests); ifm/ifm_valid, wgt/wgt_valid,
// done, err (to core); mem_rd_en, mem_addr (to SRAM); mem_rdata (from SRAM).
interface ifm_wgt_feeder_if #(
    parameter int unsigned IFM_DATA_WIDTH = 8,
    parameter int unsigned WGT_WIDTH      = 72,
    parameter int unsigned ADDR_WIDTH     = 16
);
    logic                      start_conv;
    logic                      ifm_read;
    logic                      wgt_read;
    logic [IFM_DATA_WIDTH-1:0] ifm;
    logic                      ifm_valid;
    logic [WGT_WIDTH-1:0]      wgt;
    logic                      wgt_valid;
    logic                      mem_rd_en;
    logic [ADDR_WIDTH-1:0]     mem_addr;
    logic [IFM_DATA_WIDTH-1:0] mem_rdata;
    logic                      done;
    logic                      err;

    modport master (
        output start_conv, ifm_read, wgt_read, mem_rdata,
        input  ifm, ifm_valid, wgt, wgt_valid, mem_rd_en, mem_addr, done, err
    );

    modport slave (
        input  start_conv, ifm_read, wgt_read, mem_rdata,
        output ifm, ifm_valid, wgt, wgt_valid, mem_rd_en, mem_addr, done, err
    );
endinterface

// File: rtl/ifm_wgt_feeder.sv
// ifm_wgt_feeder: memory-side feeder for the 3x3 PE-array convolution core.
// Streams input-feature-map pixels (raster order, channel by channel) and per-channel
// packed kernels out of a byte-wide synchronous-read SRAM.
// Ports:
//   clk1 - clock
//   rst  - asynchronous active-high reset
//   bus  - ifm_wgt_feeder_if.slave: core requests/responses and SRAM read port
module ifm_wgt_feeder #(
    parameter int unsigned IFM_DATA_WIDTH = 8,
    parameter int unsigned WEIGHT_WIDTH   = 8,
    parameter int unsigned KERNEL_SIZE    = 3,
    parameter int unsigned IFM_WIDTH      = 64,
    parameter int unsigned IFM_HEIGHT     = 64,
    parameter int unsigned NUM_CHANNEL    = 3,
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned IFM_BASE       = 0,
    parameter int unsigned WGT_BASE       = 12288
) (
    input logic             clk1,
    input logic             rst,
    ifm_wgt_feeder_if.slave bus
);
    localparam int unsigned KK       = KERNEL_SIZE * KERNEL_SIZE;
    localparam int unsigned NPIX     = IFM_WIDTH * IFM_HEIGHT;
    localparam int unsigned WGT_BITS = KK * WEIGHT_WIDTH;
    localparam int unsigned KW       = $clog2(KK + 1);
    localparam int unsigned CW       = $clog2(NUM_CHANNEL + 1);
    localparam int unsigned PW       = $clog2(NPIX + 1);

    typedef enum logic [1:0] {StIdle, StReady, StWload, StWfin} state_e;

    // Kernel byte k (row-major) lands in the transposed, MSB-first byte lane.
    function automatic int unsigned lane_of(input int unsigned k);
        return KK - 1 - ((k % KERNEL_SIZE) * KERNEL_SIZE + k / KERNEL_SIZE);
    endfunction

    state_e                    state_q;
    logic [PW-1:0]             pix_cnt_q;
    logic [CW-1:0]             ch_cnt_q;
    logic [ADDR_WIDTH-1:0]     pix_off_q;
    logic [CW-1:0]             wgt_ch_q;
    logic [ADDR_WIDTH-1:0]     wgt_off_q;
    logic [KW-1:0]             k_cnt_q;
    logic                      cap_q;
    logic [KW-1:0]             cap_k_q;
    logic [WGT_BITS-1:0]       wbuf_q, wbuf_d;
    logic                      pix_pend_q, last_pend_q, fin_q;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [IFM_DATA_WIDTH-1:0] ifm_q;
    logic [WGT_BITS-1:0]       wgt_q;
    logic                      ifm_valid_q, wgt_valid_q, done_q, err_q;
    logic                      req_any, pix_fetch, pix_last, rd_en;

    assign req_any   = bus.ifm_read | bus.wgt_read;
    // A simultaneous wgt_read steals the cycle, so the pixel is never fetched.
    assign pix_fetch = (state_q == StReady) && !fin_q && bus.ifm_read && !bus.wgt_read;
    assign pix_last  = (pix_cnt_q == PW'(NPIX - 1)) && (ch_cnt_q == CW'(NUM_CHANNEL - 1));
    assign rd_en     = pix_fetch || (state_q == StWload);

    always_comb begin
        addr_d = addr_q;
        if (pix_fetch) begin
            addr_d = ADDR_WIDTH'(IFM_BASE) + pix_off_q;
        end else if (state_q == StWload) begin
            addr_d = ADDR_WIDTH'(WGT_BASE) + wgt_off_q + ADDR_WIDTH'(k_cnt_q);
        end
    end

    // Merge the byte returned this cycle (read issued last cycle) into the kernel buffer.
    always_comb begin
        wbuf_d = wbuf_q;
        for (int unsigned k = 0; k < KK; k++) begin
            if (cap_q && cap_k_q == KW'(k)) begin
                wbuf_d[WEIGHT_WIDTH * lane_of(k) +: WEIGHT_WIDTH] = bus.mem_rdata;
            end
        end
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            pix_cnt_q   <= '0;
            ch_cnt_q    <= '0;
            pix_off_q   <= '0;
            wgt_ch_q    <= '0;
            wgt_off_q   <= '0;
            k_cnt_q     <= '0;
            cap_q       <= 1'b0;
            cap_k_q     <= '0;
            wbuf_q      <= '0;
            pix_pend_q  <= 1'b0;
            last_pend_q <= 1'b0;
            fin_q       <= 1'b0;
            addr_q      <= '0;
            ifm_q       <= '0;
            wgt_q       <= '0;
            ifm_valid_q <= 1'b0;
            wgt_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            wbuf_q      <= wbuf_d;
            cap_q       <= 1'b0;
            wgt_valid_q <= 1'b0;
            pix_pend_q  <= pix_fetch;
            last_pend_q <= pix_fetch && pix_last;
            ifm_valid_q <= pix_pend_q;
            done_q      <= last_pend_q;
            if (pix_pend_q) begin
                ifm_q <= bus.mem_rdata;
            end
            unique case (state_q)
                StIdle: begin
                    if (req_any) err_q <= 1'b1;
                    if (bus.start_conv) begin
                        pix_cnt_q <= '0;
                        ch_cnt_q  <= '0;
                        pix_off_q <= '0;
                        wgt_ch_q  <= '0;
                        wgt_off_q <= '0;
                        k_cnt_q   <= '0;
                        fin_q     <= 1'b0;
                        err_q     <= 1'b0;
                        state_q   <= StReady;
                    end
                end
                StReady: begin
                    if (fin_q) begin
                        // Last pixel is in flight; leave once it is delivered.
                        if (req_any) err_q <= 1'b1;
                        if (last_pend_q) state_q <= StIdle;
                    end else if (bus.wgt_read) begin
                        if (bus.ifm_read) err_q <= 1'b1;
                        if (wgt_ch_q == CW'(NUM_CHANNEL)) begin
                            err_q <= 1'b1;
                        end else begin
                            k_cnt_q <= '0;
                            state_q <= StWload;
                        end
                    end else if (bus.ifm_read) begin
                        pix_off_q <= pix_off_q + ADDR_WIDTH'(1);
                        if (pix_cnt_q == PW'(NPIX - 1)) begin
                            pix_cnt_q <= '0;
                            ch_cnt_q  <= ch_cnt_q + CW'(1);
                        end else begin
                            pix_cnt_q <= pix_cnt_q + PW'(1);
                        end
                        if (pix_last) fin_q <= 1'b1;
                    end
                end
                StWload: begin
                    if (req_any) err_q <= 1'b1;
                    cap_q   <= 1'b1;
                    cap_k_q <= k_cnt_q;
                    if (k_cnt_q == KW'(KK - 1)) begin
                        state_q <= StWfin;
                    end else begin
                        k_cnt_q <= k_cnt_q + KW'(1);
                    end
                end
                StWfin: begin
                    if (req_any) err_q <= 1'b1;
                    wgt_q       <= wbuf_d;
                    wgt_valid_q <= 1'b1;
                    wgt_off_q   <= wgt_off_q + ADDR_WIDTH'(KK);
                    wgt_ch_q    <= wgt_ch_q + CW'(1);
                    state_q     <= StReady;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.ifm       = ifm_q;
    assign bus.ifm_valid = ifm_valid_q;
    assign bus.wgt       = wgt_q;
    assign bus.wgt_valid = wgt_valid_q;
    assign bus.mem_rd_en = rd_en;
    assign bus.mem_addr  = addr_d;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_ifm_wgt_feeder.sv
// Self-checking bench for ifm_wgt_feeder: transaction-level reference model that
// schedules expected outputs per cycle, plus literal pins from the reference example.
module tb_ifm_wgt_feeder;
    localparam int IFM_BASE = 0;
    localparam int WGT_BASE = 12288;
    localparam int NPIX     = 64 * 64;
    localparam int NCH      = 3;

    logic clk1;
    logic rst;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    bit   chk_en = 0;
    logic [7:0] mem [0:65535];

    ifm_wgt_feeder_if #(.IFM_DATA_WIDTH(8), .WGT_WIDTH(72), .ADDR_WIDTH(16)) bus ();

    ifm_wgt_feeder dut (
        .clk1 (clk1),
        .rst  (rst),
        .bus  (bus)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;
    always @(posedge clk1) cyc <= cyc + 1;

    // Synchronous-read SRAM model.
    always @(posedge clk1) if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];

    // Scheduled expectations keyed by cycle number.
    logic [7:0]  ifm_evt[int];
    logic [71:0] wgt_evt[int];
    bit          done_evt[int];
    logic [15:0] rd_evt[int];
    bit          err_evt[int];

    // Abstract model state.
    bit m_active, m_fin;
    int m_ready_from, m_idle_at, m_pix, m_loads;
    logic [7:0]  cur_ifm;
    logic [71:0] cur_wgt;
    logic [15:0] cur_addr;
    bit          cur_err, ev;
    int          ndel, done_cnt;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [71:0] pack_kernel(input int ch);
        logic [71:0] v = '0;
        for (int k = 0; k < 9; k++) begin
            int r = k / 3;
            int c = k % 3;
            int b = 8 - (c * 3 + r);
            v[8*b +: 8] = mem[WGT_BASE + ch * 9 + k];
        end
        return v;
    endfunction

    task automatic model_reset();
        ifm_evt.delete(); wgt_evt.delete(); done_evt.delete(); rd_evt.delete(); err_evt.delete();
        m_active = 0; m_fin = 0; m_ready_from = 0; m_idle_at = 0; m_pix = 0; m_loads = 0;
        cur_ifm = '0; cur_wgt = '0; cur_addr = '0; cur_err = 0; ndel = 0; done_cnt = 0;
    endtask

    task automatic model_step(input int n, input bit s, input bit ir, input bit wr);
        bit req = ir | wr;
        if (m_fin && n >= m_idle_at) begin
            m_active = 0;
            m_fin    = 0;
        end
        if (!m_active) begin
            if (req) err_evt[n+1] = 1;
            if (s) begin
                err_evt[n+1] = 0;
                m_active = 1; m_ready_from = n + 1; m_pix = 0; m_loads = 0;
            end
        end else if (m_fin || n < m_ready_from) begin
            if (req) err_evt[n+1] = 1;
        end else if (wr) begin
            if (ir) err_evt[n+1] = 1;
            if (m_loads == NCH) begin
                err_evt[n+1] = 1;
            end else begin
                for (int k = 0; k < 9; k++) rd_evt[n+1+k] = 16'(WGT_BASE + m_loads * 9 + k);
                wgt_evt[n+11] = pack_kernel(m_loads);
                m_loads++;
                m_ready_from = n + 11;
            end
        end else if (ir) begin
            int ch = m_pix / NPIX;
            int p  = m_pix % NPIX;
            int a  = IFM_BASE + ch * NPIX + p;
            rd_evt[n]    = 16'(a);
            ifm_evt[n+2] = mem[a];
            if (m_pix == NCH * NPIX - 1) begin
                done_evt[n+2] = 1;
                m_fin = 1;
                m_idle_at = n + 2;
            end
            m_pix++;
        end
    endtask

    always @(negedge clk1) begin
        if (chk_en) begin
            if (err_evt.exists(cyc)) cur_err = err_evt[cyc];
            ev = ifm_evt.exists(cyc);
            if (ev) cur_ifm = ifm_evt[cyc];
            chk("ifm_valid", bus.ifm_valid, ev);
            chk("ifm", bus.ifm, cur_ifm);
            if (ev) begin
                if (ndel < 100) chk("ifm_ramp", bus.ifm, 72'(ndel));
                ndel++;
            end
            ev = wgt_evt.exists(cyc);
            if (ev) cur_wgt = wgt_evt[cyc];
            chk("wgt_valid", bus.wgt_valid, ev);
            chk("wgt", bus.wgt, cur_wgt);
            ev = done_evt.exists(cyc);
            chk("done", bus.done, ev);
            if (bus.done === 1'b1) begin
                done_cnt++;
                chk("done_with_valid", bus.ifm_valid, 1);
            end
            ev = rd_evt.exists(cyc);
            if (ev) cur_addr = rd_evt[cyc];
            chk("mem_rd_en", bus.mem_rd_en, ev);
            chk("mem_addr", bus.mem_addr, cur_addr);
            chk("err", bus.err, cur_err);
        end
    end

    task automatic cyc_drive(input bit s, input bit ir, input bit wr,
                             input bit probe = 0, input logic [15:0] want = '0);
        bus.start_conv = s;
        bus.ifm_read   = ir;
        bus.wgt_read   = wr;
        if (chk_en) model_step(cyc, s, ir, wr);
        if (probe) begin
            #1;
            chk("ch1_pix0_addr", bus.mem_addr, 72'(want));
        end
        @(posedge clk1);
        #1;
        bus.start_conv = 0;
        bus.ifm_read   = 0;
        bus.wgt_read   = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ifm"}, bus.ifm, 0);
        chk({tag, "_ifm_valid"}, bus.ifm_valid, 0);
        chk({tag, "_wgt"}, bus.wgt, 0);
        chk({tag, "_wgt_valid"}, bus.wgt_valid, 0);
        chk({tag, "_rd_en"}, bus.mem_rd_en, 0);
        chk({tag, "_addr"}, bus.mem_addr, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_err"}, bus.err, 0);
    endtask

    // Load a kernel; optionally pin the third kernel's address sequence.
    task automatic do_load(input bit pin_addr);
        cyc_drive(0, 0, 1);
        for (int k = 0; k < 9; k++) begin
            if (pin_addr) begin
                chk("kern3_rd_en", bus.mem_rd_en, 1);
                chk("kern3_addr", bus.mem_addr, 72'(12306 + k));
            end
            cyc_drive(0, 0, 0);
        end
        cyc_drive(0, 0, 0);
    endtask

    initial begin
        int lat;
        int guard;
        bit ir, st, wr;
        bus.start_conv = 0;
        bus.ifm_read   = 0;
        bus.wgt_read   = 0;
        rst = 1;
        for (int a = 0; a < 65536; a++) mem[a] = (a < 100) ? 8'(a) : 8'($urandom);
        for (int k = 0; k < 9; k++) mem[WGT_BASE + k] = 8'(k + 1);
        model_reset();

        repeat (3) @(posedge clk1);
        #1;
        chk_zero("por");
        rst = 0;
        cyc_drive(0, 0, 0);

        // Reset in the middle of a kernel load.
        cyc_drive(1, 0, 0);
        cyc_drive(0, 0, 1);
        cyc_drive(0, 0, 0);
        cyc_drive(0, 0, 0);
        chk("mid_wload_rd_en", bus.mem_rd_en, 1);
        chk("mid_wload_addr", bus.mem_addr, 72'(WGT_BASE + 2));
        rst = 1;
        #1;
        chk_zero("rst_mid");
        @(posedge clk1);
        #1;
        rst = 0;
        for (int i = 0; i < 12; i++) begin
            cyc_drive(0, 0, 0);
            chk("post_rst_wgt", bus.wgt, 0);
            chk("post_rst_wgt_valid", bus.wgt_valid, 0);
        end

        model_reset();
        chk_en = 1;

        // Request while idle is an error; start_conv then clears it.
        cyc_drive(0, 1, 0);
        cyc_drive(0, 0, 0);
        chk("idle_req_err", bus.err, 1);
        cyc_drive(1, 0, 0);
        chk("start_clr_err", bus.err, 0);

        // Run 1: kernel 0 with latency pin, 100-pixel ramp, then the full stream.
        cyc_drive(0, 0, 1);
        lat = 1;
        while (!bus.wgt_valid && lat < 30) begin
            cyc_drive(0, 0, 0);
            lat++;
        end
        chk("wgt_latency", 72'(lat), 11);
        chk("wgt_packed", bus.wgt, 72'h010407020508030609);
        for (int i = 0; i < 100; i++) cyc_drive(0, 1, 0);

        guard = 0;
        while (m_pix < NCH * NPIX && guard < 40000) begin
            if (m_loads < NCH && m_pix == m_loads * NPIX) begin
                do_load(m_loads == 2);
                if (m_loads == NCH) begin
                    chk("pre4_err", bus.err, 0);
                    cyc_drive(0, 0, 1);
                    cyc_drive(0, 0, 0);
                    chk("fourth_wgt_err", bus.err, 1);
                end
            end else begin
                ir = ($urandom_range(0, 3) != 0);
                st = ($urandom_range(0, 99) == 0);
                cyc_drive(st, ir, 0, ir && (m_pix == NPIX), 16'(IFM_BASE + NPIX));
            end
            guard++;
        end
        chk("run1_in_budget", 72'(guard < 40000), 1);
        repeat (4) cyc_drive(0, 0, 0);
        chk("done_count", 72'(done_cnt), 1);

        // Back in idle: start_conv clears the sticky error.
        cyc_drive(1, 0, 0);
        chk("restart_clr_err", bus.err, 0);

        // Run 2: collision, then random traffic including illegal requests.
        do_load(0);
        cyc_drive(0, 1, 1);
        repeat (10) cyc_drive(0, 0, 0);
        chk("collision_err", bus.err, 1);
        for (int i = 0; i < 300; i++) begin
            ir = ($urandom_range(0, 9) < 6);
            wr = ($urandom_range(0, 29) == 0);
            st = ($urandom_range(0, 49) == 0);
            cyc_drive(st, ir, wr);
        end
        repeat (5) cyc_drive(0, 0, 0);
        chk_en = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ifm_wgt_feeder.md
# ifm_wgt_feeder

Memory-side feeder for the 3x3 PE-array convolution core. It answers the core's `ifm_read` / `wgt_read` request strobes and drives the core's `ifm` and `wgt` inputs. Data is fetched from a byte-wide synchronous-read buffer SRAM. The feeder walks the input feature map in raster order, one channel at a time. For each channel it assembles the nine kernel bytes into the core's packed 72-bit weight word.

## Interface
Parameters:
- IFM_DATA_WIDTH, 8, pixel/byte width (equal to WEIGHT_WIDTH)
- WEIGHT_WIDTH, 8, kernel coefficient width
- KERNEL_SIZE, 3, kernel edge K
- IFM_WIDTH, 64, pixels per row
- IFM_HEIGHT, 64, rows per channel
- NUM_CHANNEL, 3, channels per convolution
- ADDR_WIDTH, 16, SRAM address width
- IFM_BASE, 0, byte address of channel 0 pixel 0
- WGT_BASE, 12288, byte address of channel 0 kernel byte 0

Ports:
- clk1  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- start_conv  in  1  one-cycle pulse; arms a new convolution
- ifm_read  in  1  core request for the next pixel
- wgt_read  in  1  core request for the next channel's kernel
- ifm  out  IFM_DATA_WIDTH  pixel to core (held between updates)
- ifm_valid  out  1  one-cycle pulse; `ifm` updated this cycle
- wgt  out  K*K*WEIGHT_WIDTH  packed kernel to core (held)
- wgt_valid  out  1  one-cycle pulse; `wgt` updated this cycle
- mem_rd_en  out  1  SRAM read strobe
- mem_addr  out  ADDR_WIDTH  SRAM byte address
- mem_rdata  in  8  SRAM data, valid the cycle after `mem_rd_en`
- done  out  1  one-cycle pulse after the last pixel of the last channel is delivered
- err  out  1  sticky protocol error; cleared only by `rst` or `start_conv`

## Operation
- **State machine**
  - IDLE: `start_conv` clears all counters and pointers, clears `err`, and moves to READY.
  - READY: an `ifm_read` issues one pixel fetch. A `wgt_read` moves to WLOAD.
  - WLOAD: issues K*K consecutive weight reads over K*K cycles, then moves to WFIN.
  - WFIN: captures the last byte, loads `wgt`, pulses `wgt_valid`, and returns to READY.
- **Pixel pointer** starts at IFM_BASE and increments on each accepted `ifm_read`.
  - The pixel counter runs 0..W*H-1. On wrap, the channel counter increments.
  - The fetch for pixel W*H-1 of channel NUM_CHANNEL-1 schedules `done`, and the FSM returns to IDLE after that delivery.
- **Weight pointer** starts at WGT_BASE and advances K*K per load.
  - A weight-channel counter tracks loads.
  - A `wgt_read` after NUM_CHANNEL loads is ignored and sets `err`.
- **Weight packing**: kernel byte k (row-major, r = k/K, c = k%K) is read from WGT_BASE + ch*K*K + k. It is placed at byte lane b = K*K-1-(c*K+r) of `wgt`, lane b occupying bits [8b+7:8b].
  - For K=3: k0→[71:64], k1→[47:40], k2→[23:16], k3→[63:56], k4→[39:32], k5→[15:8], k6→[55:48], k7→[31:24], k8→[7:0].
- **Collision rules**
  - `ifm_read` and `wgt_read` in the same READY cycle: the weight load wins, the pixel request is dropped, and `err` is set.
  - `ifm_read` or `wgt_read` in IDLE, WLOAD or WFIN: ignored, and `err` is set.
  - `start_conv` outside IDLE is ignored (no error).
- **Memory addressing**: `mem_addr` takes the pixel pointer in READY and the weight pointer in WLOAD. It holds its last value when `mem_rd_en` = 0.
- **Reset** (any time, including mid-load): state IDLE; `ifm`, `wgt`, `ifm_valid`, `wgt_valid`, `mem_rd_en`, `mem_addr`, `done` and `err` all go to 0; all counters and pointers are cleared.

## Timing
- **Pixel path**: `ifm_read` at cycle n.
  - `mem_rd_en` = 1 with the pixel address at cycle n (combinational from `ifm_read` and READY).
  - `mem_rdata` is valid at n+1.
  - `ifm` and `ifm_valid` are registered and visible at n+2. Latency is 2 cycles.
- Back-to-back `ifm_read` every cycle is supported at full throughput, one pixel per cycle.
- `done` pulses in the same cycle as the final `ifm_valid`.
- **Weight path**: `wgt_read` at cycle n.
  - WLOAD covers n+1..n+K*K, with `mem_rd_en` high throughout and addresses ascending.
  - Byte k is captured at n+2+k.
  - WFIN falls at n+K*K+1, where the last byte is captured.
  - `wgt` and `wgt_valid` appear at n+K*K+2, which is n+11 for K=3.
- The next `wgt_read` or `ifm_read` is accepted from cycle n+K*K+2 onward.

## Test plan
- **Reset**: assert `rst` mid-WLOAD → all outputs are 0 next cycle, state is IDLE, and `wgt` stays 0 after release.
- **Weight packing**: SRAM bytes at WGT_BASE..+8 hold 0x01..0x09; `start_conv`, then `wgt_read` → `wgt` = 0x010407020508030609 with one `wgt_valid` pulse, exactly 11 cycles after the request.
- **Pixel stream**: SRAM at IFM_BASE holds pixel p = p[7:0]; 100 consecutive `ifm_read` → `ifm` = 0x00..0x63 in order, each at request+2 cycles, one `ifm_valid` per request.
- **Full run**: 3 weight loads interleaved with 3×4096 pixel reads → channel 1 pixel 0 is read from address 4096, the third kernel is read from 12306..12314, and exactly one `done` coincides with the final `ifm_valid`.
- **Errors**:
  - `ifm_read` and `wgt_read` in the same cycle → weight load proceeds, no pixel fetch occurs, and `err` = 1 sticky.
  - A 4th `wgt_read` → ignored with `err` = 1.
  - `start_conv` clears `err`.
